// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg -- shared definitions for the MAC row feeder.
//
// Contents:
//   * Row instruction encoding (inst_w = {mode, exec, weight_load}).
//   * Feeder FSM state enumeration.
//   * make_inst(): assembles a row instruction from its three flag bits.
// ----------------------------------------------------------------------------
package mac_pkg;

    // Row instruction encoding
    localparam logic [2:0] INST_NOP       = 3'b000;
    localparam int         INST_WLOAD_BIT = 0;
    localparam int         INST_EXEC_BIT  = 1;
    localparam int         INST_MODE_BIT  = 2;

    // Feeder FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    // Build a row instruction word from its flag bits.
    function automatic logic [2:0] make_inst(input logic mode_b,
                                             input logic exec_b,
                                             input logic wload_b);
        logic [2:0] inst_v;
        inst_v                 = INST_NOP;
        inst_v[INST_MODE_BIT]  = mode_b;
        inst_v[INST_EXEC_BIT]  = exec_b;
        inst_v[INST_WLOAD_BIT] = wload_b;
        return inst_v;
    endfunction

endpackage : mac_pkg

// File: rtl/mac_row_feeder.sv
// ----------------------------------------------------------------------------
// mac_row_feeder -- sequences a weight load followed by activation streaming
// into a row of MAC columns.
//
// A start request in IDLE latches the operand mode and opens LOAD, where a
// fixed number of weight beats (2*col in 2-bit mode, col in 4-bit mode) is
// accepted. EXEC then streams activation beats until one flagged s_last is
// accepted, after which DRAIN issues col bubble cycles and done pulses.
// Every accepted beat is forwarded to the row one cycle later, split into
// two half-nibble lanes, together with its row instruction.
//
// Parameters:
//   bw    - width of each half-nibble lane to the row
//   b_bw  - width of one upstream beat (2*bw)
//   col   - number of MAC columns fed
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   start      in   begin a load-then-execute sequence (IDLE only)
//   mode       in   0 = 2-bit, 1 = 4-bit; latched when start is accepted
//   s_valid    in   upstream beat valid
//   s_data     in   upstream beat (weight in LOAD, activation in EXEC)
//   s_last     in   final activation beat marker
//   s_ready    out  beat accepted this cycle when s_valid is also high
//   in_w0      out  low half of the forwarded beat
//   in_w1      out  high half of the forwarded beat
//   inst_w     out  row instruction {mode, exec, weight_load}
//   busy       out  sequence in progress
//   done       out  one-cycle completion pulse
//   act_count  out  (MAC_FEEDER_ACT_CNT_EN only) saturating count of
//                   activation beats accepted since the last start
//
// Build option: define MAC_FEEDER_ACT_CNT_EN to add the act_count output.
// ----------------------------------------------------------------------------
module mac_row_feeder
    import mac_pkg::*;
#(
    parameter int bw   = 2,
    parameter int b_bw = 4,
    parameter int col  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    input  logic            s_valid,
    input  logic [b_bw-1:0] s_data,
    input  logic            s_last,
    output logic            s_ready,
    output logic [bw-1:0]   in_w0,
    output logic [bw-1:0]   in_w1,
    output logic [2:0]      inst_w,
    output logic            busy,
    output logic            done
`ifdef MAC_FEEDER_ACT_CNT_EN
    ,
    output logic [15:0]     act_count
`endif
);

    localparam int CW = $clog2(2 * col + 1);

    // Terminal counter values: last weight beat of each mode, last drain cycle
    localparam logic [CW-1:0] LOAD2_LAST = CW'(2 * col - 1);
    localparam logic [CW-1:0] LOAD4_LAST = CW'(col - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(col - 1);

    state_e          state_q, state_d;
    logic            mode_q,  mode_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [bw-1:0]   w0_q,    w0_d;
    logic [bw-1:0]   w1_q,    w1_d;
    logic [2:0]      inst_q,  inst_d;
    logic            done_q,  done_d;

    logic            ready_s;
    logic            accept_s;
    logic [CW-1:0]   load_last_s;

    // Handshake decode and weight-count target for the latched mode
    always_comb begin
        ready_s     = (state_q == ST_LOAD) || (state_q == ST_EXEC);
        accept_s    = s_valid && ready_s;
        load_last_s = mode_q ? LOAD4_LAST : LOAD2_LAST;
    end

    // FSM next-state, mode latch and beat/drain counter
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Only the weight count ends LOAD; s_last is not consulted.
                if (accept_s) begin
                    if (cnt_q == load_last_s) begin
                        cnt_d   = '0;
                        state_d = ST_EXEC;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_EXEC: begin
                if (accept_s && s_last) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_DRAIN: begin
                // done is registered, so it lands on the row output cycle
                // that follows the last drain cycle, in step with the data.
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                mode_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Row output: forward the accepted beat, otherwise issue a bubble
    always_comb begin
        if (accept_s) begin
            w0_d   = s_data[bw-1:0];
            w1_d   = s_data[b_bw-1:bw];
            inst_d = make_inst(mode_q, state_q == ST_EXEC, state_q == ST_LOAD);
        end else begin
            w0_d   = '0;
            w1_d   = '0;
            inst_d = INST_NOP;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            inst_q  <= INST_NOP;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
        end
    end

    assign s_ready = ready_s;
    assign busy    = (state_q != ST_IDLE);
    assign in_w0   = w0_q;
    assign in_w1   = w1_q;
    assign inst_w  = inst_q;
    assign done    = done_q;

`ifdef MAC_FEEDER_ACT_CNT_EN
    logic [15:0] act_q, act_d;

    // Activation beat counter: clears on an accepted start, saturates
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            act_d = 16'd0;
        end else if ((state_q == ST_EXEC) && accept_s && (act_q != 16'hFFFF)) begin
            act_d = act_q + 16'd1;
        end else begin
            act_d = act_q;
        end
    end

    // Activation counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_q <= 16'd0;
        end else begin
            act_q <= act_d;
        end
    end

    assign act_count = act_q;
`endif

endmodule : mac_row_feeder

// File: tb/tb_mac_row_feeder.sv
// ----------------------------------------------------------------------------
// tb_mac_row_feeder -- directed self-checking bench for mac_row_feeder.
// Default parameters (bw=2, b_bw=4, col=4). Inputs change 1 ns after each
// rising edge; outputs are checked at the same point.
// ----------------------------------------------------------------------------
module tb_mac_row_feeder;

    logic       clk;
    logic       reset;
    logic       start;
    logic       mode;
    logic       s_valid;
    logic [3:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic [1:0] in_w0;
    logic [1:0] in_w1;
    logic [2:0] inst_w;
    logic       busy;
    logic       done;
`ifdef MAC_FEEDER_ACT_CNT_EN
    logic [15:0] act_count;
`endif

    int n_asserts;
    int n_fail;

    mac_row_feeder #(.bw(2), .b_bw(4), .col(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .in_w0   (in_w0),
        .in_w1   (in_w1),
        .inst_w  (inst_w),
        .busy    (busy),
        .done    (done)
`ifdef MAC_FEEDER_ACT_CNT_EN
        ,
        .act_count (act_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the row output pair: instruction and forwarded nibble
    task automatic chk_row(input string tag, input logic [2:0] ei, input logic [3:0] ed);
        chk({tag, " inst_w"}, 32'(inst_w), 32'(ei));
        chk({tag, " data"},   32'({in_w1, in_w0}), 32'(ed));
    endtask

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [3:0] d, input logic l, input logic [2:0] ei);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        step();
        chk_row(tag, ei, d);
    endtask

    // Four drain bubbles after the last exec beat, done on the fourth
    task automatic drain_check(input string tag);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_row({tag, " bubble"}, 3'b000, 4'd0);
            chk({tag, " done"}, 32'(done), (k == 4) ? 32'd1 : 32'd0);
            chk({tag, " busy"}, 32'(busy), (k == 4) ? 32'd0 : 32'd1);
        end
        step();
        chk({tag, " done drop"}, 32'(done), 32'd0);
    endtask

    logic [3:0] wts [8];

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        wts[0] = 4'h1; wts[1] = 4'h2; wts[2] = 4'h3; wts[3] = 4'h4;
        wts[4] = 4'h8; wts[5] = 4'h0; wts[6] = 4'h9; wts[7] = 4'h7;

        reset   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        s_valid = 1'b0;
        s_data  = 4'd0;
        s_last  = 1'b0;
        #3;
        // Reset state
        chk_row("reset", 3'b000, 4'd0);
        chk("reset busy",    32'(busy),    32'd0);
        chk("reset done",    32'(done),    32'd0);
        chk("reset s_ready", 32'(s_ready), 32'd0);
`ifdef MAC_FEEDER_ACT_CNT_EN
        chk("reset act_count", 32'(act_count), 32'd0);
`endif
        step();
        reset = 1'b1;
        step();

        // IDLE ignores s_valid
        s_valid = 1'b1;
        s_data  = 4'hA;
        chk("idle s_ready", 32'(s_ready), 32'd0);
        step();
        chk_row("idle", 3'b000, 4'd0);
        s_valid = 1'b0;

        // 2-bit mode: 8 weights with s_valid held high, then EXEC
        do_start(1'b0);
        chk_row("start", 3'b000, 4'd0);
        chk("load busy",    32'(busy),    32'd1);
        chk("load s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            beat("m0 weight", wts[i], 1'b0, 3'b001);
        end
        beat("m0 exec", 4'h5, 1'b1, 3'b010);
        chk("drain s_ready", 32'(s_ready), 32'd0);
        drain_check("m0");

        // 4-bit mode: weights 1,E,7,8 then activations 0..15
        do_start(1'b1);
        beat("m1 w0", 4'h1, 1'b1, 3'b101);  // s_last ignored in LOAD
        beat("m1 w1", 4'hE, 1'b0, 3'b101);
        beat("m1 w2", 4'h7, 1'b0, 3'b101);
        beat("m1 w3", 4'h8, 1'b0, 3'b101);
        for (int i = 0; i < 16; i++) begin
            beat("m1 act", 4'(i), (i == 15), 3'b110);
        end
        drain_check("m1");
`ifdef MAC_FEEDER_ACT_CNT_EN
        chk("act_count after 16", 32'(act_count), 32'd16);
`endif

        // Start ignored in LOAD: asserted with mode=1 on the 3rd weight
        do_start(1'b0);
`ifdef MAC_FEEDER_ACT_CNT_EN
        chk("act_count cleared", 32'(act_count), 32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            start = (i == 2);
            mode  = (i == 2);
            beat("ign weight", wts[i], 1'b0, 3'b001);
        end
        start = 1'b0;
        mode  = 1'b0;

        // Two idle cycles mid-EXEC become exactly two bubbles
        beat("gap a0", 4'h3, 1'b0, 3'b010);
        s_valid = 1'b0;
        s_data  = 4'hF;
        step();
        chk_row("gap bubble1", 3'b000, 4'd0);
        chk("gap s_ready", 32'(s_ready), 32'd1);
        step();
        chk_row("gap bubble2", 3'b000, 4'd0);
        beat("gap a1", 4'hC, 1'b0, 3'b010);
        beat("gap a2", 4'h6, 1'b1, 3'b010);
        drain_check("gap");

        // Reset pulsed mid-EXEC
        do_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            beat("rst weight", wts[i], 1'b0, 3'b101);
        end
        beat("rst act0", 4'h2, 1'b0, 3'b110);
        reset = 1'b0;
        #1;
        chk_row("rst async", 3'b000, 4'd0);
        chk("rst busy",    32'(busy),    32'd0);
        chk("rst s_ready", 32'(s_ready), 32'd0);
        chk("rst done",    32'(done),    32'd0);
        step();
        reset   = 1'b1;
        s_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post-rst done", 32'(done), 32'd0);
            chk("post-rst busy", 32'(busy), 32'd0);
        end

        // Fresh sequence after reset completes normally
        do_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            beat("fresh weight", wts[7 - i], 1'b0, 3'b001);
        end
        beat("fresh exec", 4'hB, 1'b1, 3'b010);
        drain_check("fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_mac_row_feeder
